// File: rtl/butterfly_pkg.sv
// Shared mode encodings and fixed-point helpers for the pipelined radix-2 butterfly.
package butterfly_pkg;

  localparam logic MODE_DIT = 1'b0;
  localparam logic MODE_DIF = 1'b1;

  typedef logic signed [63:0] wide_t;

  // Round half toward +inf, then arithmetic shift right; shift must be >= 1.
  function automatic wide_t round_shr(input wide_t value, input int unsigned shift);
    wide_t bias;
    bias = 64'sd1 <<< (shift - 1);
    return (value + bias) >>> shift;
  endfunction

  function automatic wide_t sat_w(input wide_t value, input int unsigned width);
    wide_t hi;
    wide_t lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/bf_cmul.sv
// Two-stage complex multiply a*b: registered partial products, then registered
// half-up round and sum. Advances only when en_i is high.
module bf_cmul
  import butterfly_pkg::*;
#(
  parameter int W_A  = 17,
  parameter int W_B  = 16,
  parameter int FRAC = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    valid_i,
  input  logic signed [W_A-1:0]   a_r_i,
  input  logic signed [W_A-1:0]   a_i_i,
  input  logic signed [W_B-1:0]   b_r_i,
  input  logic signed [W_B-1:0]   b_i_i,
  output logic                    valid_o,
  output logic signed [W_B+1:0]   p_r_o,
  output logic signed [W_B+1:0]   p_i_o
);

  localparam int W_P = W_A + W_B;
  localparam int W_O = W_B + 2;

  logic signed [W_P-1:0] rr_q, ii_q, ri_q, ir_q;
  logic                  v1_q, v2_q;
  logic signed [W_O-1:0] p_r_q, p_i_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      rr_q  <= '0;
      ii_q  <= '0;
      ri_q  <= '0;
      ir_q  <= '0;
      p_r_q <= '0;
      p_i_q <= '0;
    end else if (en_i) begin
      v1_q  <= valid_i;
      rr_q  <= W_P'(a_r_i) * W_P'(b_r_i);
      ii_q  <= W_P'(a_i_i) * W_P'(b_i_i);
      ri_q  <= W_P'(a_r_i) * W_P'(b_i_i);
      ir_q  <= W_P'(a_i_i) * W_P'(b_r_i);
      v2_q  <= v1_q;
      // Twiddles are bounded by |1.0|, so the rounded sum always fits W_B+2 bits.
      p_r_q <= W_O'(round_shr(64'(rr_q) - 64'(ii_q), FRAC));
      p_i_q <= W_O'(round_shr(64'(ri_q) + 64'(ir_q), FRAC));
    end
  end

  assign valid_o = v2_q;
  assign p_r_o   = p_r_q;
  assign p_i_o   = p_i_q;

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 butterfly (DIT/DIF) with half-up rounding,
// optional /2 scaling and output saturation behind a valid/ready handshake.
module butterfly_pipe
  import butterfly_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic         mode,
  input  logic         scale,
  input  logic [W-1:0] x1_r,
  input  logic [W-1:0] x1_i,
  input  logic [W-1:0] x2_r,
  input  logic [W-1:0] x2_i,
  input  logic [W-1:0] w_r,
  input  logic [W-1:0] w_i,
  output logic         y_valid,
  input  logic         y_ready,
  output logic [W-1:0] y1_r,
  output logic [W-1:0] y1_i,
  output logic [W-1:0] y2_r,
  output logic [W-1:0] y2_i,
  output logic         sat
);

  localparam int W_S = W + 1;
  localparam int W_T = W + 2;

  logic                  advance, accept;
  logic signed [W_S-1:0] ax1_r, ax1_i, ax2_r, ax2_i;
  logic signed [W_S-1:0] cm_a_r, cm_a_i, aux_r_d, aux_i_d;
  logic signed [W_S-1:0] s1_aux_r_q, s1_aux_i_q, s2_aux_r_q, s2_aux_i_q;
  logic                  s1_mode_q, s1_scale_q, s2_mode_q, s2_scale_q;
  logic                  t_valid;
  logic signed [W_T-1:0] t_r, t_i;
  wide_t                 pre [4];
  wide_t                 scl [4];
  logic [W-1:0]          y_d [4];
  logic [3:0]            clip;
  logic                  y_valid_q, sat_q;
  logic [W-1:0]          y_q [4];

  assign advance = !y_valid_q || y_ready;
  assign ready   = advance;
  assign accept  = start && advance;

  assign ax1_r = W_S'($signed(x1_r));
  assign ax1_i = W_S'($signed(x1_i));
  assign ax2_r = W_S'($signed(x2_r));
  assign ax2_i = W_S'($signed(x2_i));

  // The multiplier always starts at S1: it sees x2 for DIT and d = x1-x2 for DIF,
  // while the side path carries x1 (DIT) or s = x1+x2 (DIF) alongside it.
  always_comb begin
    if (mode == MODE_DIF) begin
      cm_a_r  = ax1_r - ax2_r;
      cm_a_i  = ax1_i - ax2_i;
      aux_r_d = ax1_r + ax2_r;
      aux_i_d = ax1_i + ax2_i;
    end else begin
      cm_a_r  = ax2_r;
      cm_a_i  = ax2_i;
      aux_r_d = ax1_r;
      aux_i_d = ax1_i;
    end
  end

  bf_cmul #(.W_A(W_S), .W_B(W), .FRAC(FRAC)) u_cmul (
    .clk     (clk),
    .rst     (rst),
    .en_i    (advance),
    .valid_i (accept),
    .a_r_i   (cm_a_r),
    .a_i_i   (cm_a_i),
    .b_r_i   ($signed(w_r)),
    .b_i_i   ($signed(w_i)),
    .valid_o (t_valid),
    .p_r_o   (t_r),
    .p_i_o   (t_i)
  );

  always_comb begin
    if (s2_mode_q == MODE_DIT) begin
      pre[0] = 64'(s2_aux_r_q) + 64'(t_r);
      pre[1] = 64'(s2_aux_i_q) + 64'(t_i);
      pre[2] = 64'(s2_aux_r_q) - 64'(t_r);
      pre[3] = 64'(s2_aux_i_q) - 64'(t_i);
    end else begin
      pre[0] = 64'(s2_aux_r_q);
      pre[1] = 64'(s2_aux_i_q);
      pre[2] = 64'(t_r);
      pre[3] = 64'(t_i);
    end
    for (int k = 0; k < 4; k++) begin
      scl[k]  = s2_scale_q ? round_shr(pre[k], 1) : pre[k];
      y_d[k]  = W'(sat_w(scl[k], W));
      clip[k] = (sat_w(scl[k], W) != scl[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_aux_r_q <= '0;
      s1_aux_i_q <= '0;
      s2_aux_r_q <= '0;
      s2_aux_i_q <= '0;
      s1_mode_q  <= MODE_DIT;
      s2_mode_q  <= MODE_DIT;
      s1_scale_q <= 1'b0;
      s2_scale_q <= 1'b0;
      y_valid_q  <= 1'b0;
      sat_q      <= 1'b0;
      y_q        <= '{default: '0};
    end else if (advance) begin
      s1_aux_r_q <= aux_r_d;
      s1_aux_i_q <= aux_i_d;
      s1_mode_q  <= mode;
      s1_scale_q <= scale;
      s2_aux_r_q <= s1_aux_r_q;
      s2_aux_i_q <= s1_aux_i_q;
      s2_mode_q  <= s1_mode_q;
      s2_scale_q <= s1_scale_q;
      y_valid_q  <= t_valid;
      sat_q      <= t_valid && (|clip);
      if (t_valid) y_q <= y_d;
    end
  end

  assign y_valid = y_valid_q;
  assign sat     = sat_q;
  assign y1_r    = y_q[0];
  assign y1_i    = y_q[1];
  assign y2_r    = y_q[2];
  assign y2_i    = y_q[3];

endmodule

// File: tb/tb_butterfly_pipe.sv
// Bench for butterfly_pipe: directed vectors, a stalled stream, random traffic and
// a mid-stream reset, all scored against a plain-arithmetic butterfly model.
module tb_butterfly_pipe;

  localparam int W    = 16;
  localparam int FRAC = 8;

  typedef struct packed {
    logic [W-1:0] y1r;
    logic [W-1:0] y1i;
    logic [W-1:0] y2r;
    logic [W-1:0] y2i;
    logic         sat;
  } res_t;

  logic         clk = 1'b0;
  logic         rst, start, mode, scale, y_ready;
  logic [W-1:0] x1_r, x1_i, x2_r, x2_i, w_r, w_i;
  logic         ready, y_valid, sat;
  logic [W-1:0] y1_r, y1_i, y2_r, y2_i;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_xfer   = 0;
  res_t exp_q[$];
  logic got, accepted, held;
  res_t got_res, held_res;

  always #5 clk = ~clk;

  butterfly_pipe #(.W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .mode(mode), .scale(scale),
    .x1_r(x1_r), .x1_i(x1_i), .x2_r(x2_r), .x2_i(x2_i), .w_r(w_r), .w_i(w_i),
    .y_valid(y_valid), .y_ready(y_ready),
    .y1_r(y1_r), .y1_i(y1_i), .y2_r(y2_r), .y2_i(y2_i), .sat(sat)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint rnd(input longint v, input int sh);
    return (v + (longint'(1) <<< (sh - 1))) >>> sh;
  endfunction

  function automatic res_t model(input bit md, input bit sc,
                                 input longint a_r, a_i, b_r, b_i, c_r, c_i);
    longint v[4];
    longint hi, lo, d_r, d_i;
    res_t   r;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -hi - 1;
    if (!md) begin
      d_r  = rnd(b_r * c_r - b_i * c_i, FRAC);
      d_i  = rnd(b_r * c_i + b_i * c_r, FRAC);
      v[0] = a_r + d_r;
      v[1] = a_i + d_i;
      v[2] = a_r - d_r;
      v[3] = a_i - d_i;
    end else begin
      d_r  = a_r - b_r;
      d_i  = a_i - b_i;
      v[0] = a_r + b_r;
      v[1] = a_i + b_i;
      v[2] = rnd(d_r * c_r - d_i * c_i, FRAC);
      v[3] = rnd(d_r * c_i + d_i * c_r, FRAC);
    end
    r.sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (sc) v[k] = rnd(v[k], 1);
      if (v[k] > hi) begin
        v[k]  = hi;
        r.sat = 1'b1;
      end else if (v[k] < lo) begin
        v[k]  = lo;
        r.sat = 1'b1;
      end
    end
    r.y1r = W'(v[0]);
    r.y1i = W'(v[1]);
    r.y2r = W'(v[2]);
    r.y2i = W'(v[3]);
    return r;
  endfunction

  // One clock: drive start/y_ready, sample just after the falling edge, score, advance.
  task automatic cycle(input logic st, input logic yr);
    res_t cur, e;
    start    = st;
    y_ready  = yr;
    #1;
    got      = 1'b0;
    accepted = 1'b0;
    cur      = {y1_r, y1_i, y2_r, y2_i, sat};
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      check_val("ready_rule", ready, !y_valid || yr);
      if (y_valid && !yr) begin
        if (held) check_val("hold_stable", cur, held_res);
        held     = 1'b1;
        held_res = cur;
      end else begin
        held = 1'b0;
      end
      if (y_valid && yr) begin
        check_val("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_val("y1_r", cur.y1r, e.y1r);
          check_val("y1_i", cur.y1i, e.y1i);
          check_val("y2_r", cur.y2r, e.y2r);
          check_val("y2_i", cur.y2i, e.y2i);
          check_val("sat", cur.sat, e.sat);
        end
        got     = 1'b1;
        got_res = cur;
        n_xfer++;
      end
      if (st && ready) begin
        accepted = 1'b1;
        exp_q.push_back(model(mode, scale, $signed(x1_r), $signed(x1_i), $signed(x2_r),
                              $signed(x2_i), $signed(w_r), $signed(w_i)));
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_ops();
    x1_r = W'($urandom);
    x1_i = W'($urandom);
    x2_r = W'($urandom);
    x2_i = W'($urandom);
    w_r  = W'(int'($urandom_range(512, 0)) - 256);
    w_i  = W'(int'($urandom_range(512, 0)) - 256);
  endtask

  task automatic directed(input string tag, input logic md, input logic sc,
                          input logic [W-1:0] a_r, a_i, b_r, b_i, c_r, c_i, input res_t lit);
    bit found = 1'b0;
    mode = md;  scale = sc;
    x1_r = a_r; x1_i = a_i; x2_r = b_r; x2_i = b_i; w_r = c_r; w_i = c_i;
    cycle(1'b1, 1'b1);
    check_val({tag, "_accept"}, accepted, 1);
    for (int n = 1; n <= 8; n++) begin
      cycle(1'b0, 1'b1);
      if (got && !found) begin
        found = 1'b1;
        check_val({tag, "_latency"}, 128'(n), 3);
        check_val(tag, got_res, lit);
      end
    end
    check_val({tag, "_seen"}, found, 1);
  endtask

  initial begin
    int acc, cyc, base;
    rst = 1'b1; start = 1'b0; mode = 1'b0; scale = 1'b0; y_ready = 1'b1;
    x1_r = '0; x1_i = '0; x2_r = '0; x2_i = '0; w_r = '0; w_i = '0;
    held = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("reset_y_valid", y_valid, 0);
    check_val("reset_ready", ready, 1);
    check_val("reset_outputs", {y1_r, y1_i, y2_r, y2_i, sat}, 0);
    @(negedge clk);

    directed("dit_basic", 1'b0, 1'b0, 16'hFC00, 16'h0000, 16'h0200, 16'h0000, 16'h00B5, 16'hFF4B,
             {16'hFD6A, 16'hFE96, 16'hFA96, 16'h016A, 1'b0});
    directed("dif_basic", 1'b1, 1'b0, 16'hFC00, 16'h0000, 16'h0200, 16'h0000, 16'h00B5, 16'hFF4B,
             {16'hFE00, 16'h0000, 16'hFBC2, 16'h043E, 1'b0});
    directed("dit_sat", 1'b0, 1'b0, 16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000,
             {16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b1});
    directed("dit_sat_scaled", 1'b0, 1'b1, 16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000,
             {16'h7F00, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    directed("round_pos", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0080, 16'h0000,
             {16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1'b0});
    directed("round_neg", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000,
             {16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0});

    // Eight back-to-back butterflies with alternating mode/scale and a 4-cycle downstream stall.
    base = n_xfer;
    acc  = 0;
    cyc  = 0;
    rand_ops();
    mode = 1'b0; scale = 1'b0;
    while (acc < 8 && cyc < 40) begin
      cycle(1'b1, !(cyc >= 5 && cyc < 9));
      if (cyc >= 5 && cyc < 9) check_val("stall_ready", ready, 0);
      if (accepted) begin
        acc++;
        rand_ops();
        mode  = acc[0];
        scale = acc[1];
      end
      cyc++;
    end
    for (int n = 0; n < 10; n++) cycle(1'b0, 1'b1);
    check_val("stream_count", 128'(n_xfer - base), 8);
    check_val("stream_drained", 128'(exp_q.size()), 0);

    for (int n = 0; n < 300; n++) begin
      rand_ops();
      mode  = 1'($urandom);
      scale = 1'($urandom);
      cycle($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
    end
    for (int n = 0; n < 12; n++) cycle(1'b0, 1'b1);
    check_val("random_drained", 128'(exp_q.size()), 0);

    // Two butterflies in flight, then a one-cycle reset with start still asserted.
    rand_ops();
    cycle(1'b1, 1'b1);
    rand_ops();
    cycle(1'b1, 1'b1);
    rst = 1'b1;
    cycle(1'b1, 1'b1);
    rst   = 1'b0;
    start = 1'b0;
    #1;
    check_val("midrst_y_valid", y_valid, 0);
    check_val("midrst_ready", ready, 1);
    check_val("midrst_outputs", {y1_r, y1_i, y2_r, y2_i, sat}, 0);
    @(negedge clk);
    base = n_xfer;
    for (int n = 0; n < 8; n++) cycle(1'b0, 1'b1);
    check_val("midrst_no_stale", 128'(n_xfer - base), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
